// File: rtl/gt_cache_miss_ctrl_if.sv
// Bus bundle for the cache miss controller: CPU load port, main-memory line port and data-array port.
// The controller connects through the master modport; the surrounding system uses slave.
interface gt_cache_miss_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int OFF_W  = 5,
    parameter int IDX_W  = 4
);
    localparam int LINE_W = 8 << OFF_W;

    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_ready;
    logic              cpu_rvalid;
    logic [7:0]        cpu_rdata;
    logic              flush;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [LINE_W-1:0] mem_data;

    logic [IDX_W-1:0]  arr_ridx;
    logic [LINE_W-1:0] arr_rdata;
    logic              arr_we;
    logic [IDX_W-1:0]  arr_widx;
    logic [LINE_W-1:0] arr_wdata;

    modport master (
        input  cpu_req, cpu_addr, flush, mem_ack, mem_data, arr_rdata,
        output cpu_ready, cpu_rvalid, cpu_rdata, mem_req, mem_addr,
               arr_ridx, arr_we, arr_widx, arr_wdata
    );

    modport slave (
        output cpu_req, cpu_addr, flush, mem_ack, mem_data, arr_rdata,
        input  cpu_ready, cpu_rvalid, cpu_rdata, mem_req, mem_addr,
               arr_ridx, arr_we, arr_widx, arr_wdata
    );
endinterface

// File: rtl/gt_cache_miss_ctrl.sv
// Direct-mapped byte-read cache controller: tag/valid arrays, lookup, line fill on miss, flush.
// Define CACHE_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module gt_cache_miss_ctrl #(
    parameter int ADDR_W = 32,
    parameter int OFF_W  = 5,
    parameter int IDX_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gt_cache_miss_ctrl_if.master  bus
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt
`endif
);
    localparam int LINE_W = 8 << OFF_W;
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int LINES  = 1 << IDX_W;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOOKUP = 2'd1;
    localparam logic [1:0] MISS   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              flush_pend_q, flush_pend_d;
    logic              cpu_rvalid_q, cpu_rvalid_d;
    logic [7:0]        cpu_rdata_q, cpu_rdata_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              arr_we_q, arr_we_d;
    logic [IDX_W-1:0]  arr_widx_q, arr_widx_d;
    logic [LINE_W-1:0] arr_wdata_q, arr_wdata_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]  tags_q [LINES];
    logic              tag_we;

    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic [OFF_W-1:0]  off;
    logic              hit;
    logic              cpu_ready;

    assign tag       = addr_q[ADDR_W-1:IDX_W+OFF_W];
    assign idx       = addr_q[IDX_W+OFF_W-1:OFF_W];
    assign off       = addr_q[OFF_W-1:0];
    assign hit       = valid_q[idx] && (tags_q[idx] == tag);
    assign cpu_ready = (state_q == IDLE) && !bus.flush && !flush_pend_q;

    assign bus.cpu_ready  = cpu_ready;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.arr_ridx   = idx;
    assign bus.arr_we     = arr_we_q;
    assign bus.arr_widx   = arr_widx_q;
    assign bus.arr_wdata  = arr_wdata_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        flush_pend_d = flush_pend_q;
        cpu_rvalid_d = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        arr_we_d     = 1'b0;
        arr_widx_d   = arr_widx_q;
        arr_wdata_d  = arr_wdata_q;
        valid_d      = valid_q;
        tag_we       = 1'b0;

        // A flush seen while busy is deferred until the controller is back in IDLE.
        if (state_q != IDLE && bus.flush)
            flush_pend_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (bus.flush || flush_pend_q) begin
                    valid_d      = '0;
                    flush_pend_d = 1'b0;
                end else if (bus.cpu_req) begin
                    addr_d  = bus.cpu_addr;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    cpu_rdata_d  = bus.arr_rdata[{off, 3'b000} +: 8];
                    cpu_rvalid_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    state_d    = MISS;
                end
            end
            MISS: begin
                if (bus.mem_ack && mem_req_q) begin
                    arr_we_d     = 1'b1;
                    arr_widx_d   = idx;
                    arr_wdata_d  = bus.mem_data;
                    tag_we       = 1'b1;
                    valid_d[idx] = 1'b1;
                    cpu_rdata_d  = bus.mem_data[{off, 3'b000} +: 8];
                    cpu_rvalid_d = 1'b1;
                    mem_req_d    = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            flush_pend_q <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            arr_we_q     <= 1'b0;
            arr_widx_q   <= '0;
            arr_wdata_q  <= '0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            flush_pend_q <= flush_pend_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            arr_we_q     <= arr_we_d;
            arr_widx_q   <= arr_widx_d;
            arr_wdata_q  <= arr_wdata_d;
            valid_q      <= valid_d;
        end
    end

    // Tags need no reset: the valid bits gate every comparison.
    always_ff @(posedge clk) begin
        if (tag_we)
            tags_q[idx] <= tag;
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == LOOKUP) begin
            if (hit && hit_cnt_q != 32'hFFFF_FFFF)
                hit_cnt_d = hit_cnt_q + 32'd1;
            if (!hit && miss_cnt_q != 32'hFFFF_FFFF)
                miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_gt_cache_miss_ctrl.sv
// Directed testbench for gt_cache_miss_ctrl with a behavioural data array and hand-driven memory port.
// Define CACHE_STATS_EN to also exercise the hit/miss counters.
module tb_gt_cache_miss_ctrl;
    localparam int ADDR_W = 32;
    localparam int OFF_W  = 5;
    localparam int IDX_W  = 4;
    localparam int LINE_W = 256;

    logic clk = 1'b0;
    logic rst_n;
    int   tests_run    = 0;
    int   tests_failed = 0;

    logic [LINE_W-1:0] arr_mem [16];
    logic [LINE_W-1:0] line_a, line_b, line_c;

    always #5 clk = ~clk;

    gt_cache_miss_ctrl_if #(.ADDR_W(ADDR_W), .OFF_W(OFF_W), .IDX_W(IDX_W)) bus ();

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    gt_cache_miss_ctrl #(.ADDR_W(ADDR_W), .OFF_W(OFF_W), .IDX_W(IDX_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.master)
`ifdef CACHE_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    // External line data array: combinational read, write on the registered pulse.
    assign bus.arr_rdata = arr_mem[bus.arr_ridx];
    always @(posedge clk) if (bus.arr_we) arr_mem[bus.arr_widx] <= bus.arr_wdata;

    // Byte k of a line is seed + 3k.
    function automatic logic [LINE_W-1:0] make_line(input logic [7:0] seed);
        logic [LINE_W-1:0] l;
        for (int k = 0; k < 32; k++) l[8*k +: 8] = seed + 8'(3*k);
        return l;
    endfunction

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge in IDLE; returns at the negedge after the accept edge.
    task automatic start_req(input logic [31:0] addr);
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = addr;
        cycle();
        bus.cpu_req  = 1'b0;
    endtask

    // Returns at the negedge after the ack edge (rvalid cycle).
    task automatic ack_line(input logic [LINE_W-1:0] l);
        bus.mem_data = l;
        bus.mem_ack  = 1'b1;
        cycle();
        bus.mem_ack  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.flush = 1'b0;
        bus.mem_ack = 1'b0; bus.mem_data = '0;
        repeat (2) @(negedge clk);
        tests_run++; if (bus.cpu_rvalid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rvalid: got %b want 0", bus.cpu_rvalid); end
        tests_run++; if (bus.mem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_mem_req: got %b want 0", bus.mem_req); end
        tests_run++; if (bus.arr_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_arr_we: got %b want 0", bus.arr_we); end
        tests_run++; if (bus.cpu_rdata !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_rdata: got %h want 00", bus.cpu_rdata); end
        tests_run++; if (bus.mem_addr !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
        tests_run++; if (bus.arr_wdata !== '0) begin tests_failed++; $display("[TB] FAIL reset_arr_wdata: got %h want 0", bus.arr_wdata); end
        tests_run++; if (bus.cpu_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_ready: got %b want 1", bus.cpu_ready); end
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_cold_miss();
        start_req(32'h0000_0123);
        tests_run++; if (bus.cpu_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL cold_ready_busy: got %b want 0", bus.cpu_ready); end
        tests_run++; if (bus.mem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL cold_req_early: got %b want 0", bus.mem_req); end
        cycle();
        tests_run++; if (bus.mem_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL cold_mem_req: got %b want 1", bus.mem_req); end
        tests_run++; if (bus.mem_addr !== 32'h0000_0120) begin tests_failed++; $display("[TB] FAIL cold_mem_addr: got %h want 00000120", bus.mem_addr); end
        cycle(); cycle();
        tests_run++; if (bus.mem_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL cold_req_held: got %b want 1", bus.mem_req); end
        tests_run++; if (bus.cpu_rvalid !== 1'b0) begin tests_failed++; $display("[TB] FAIL cold_rvalid_wait: got %b want 0", bus.cpu_rvalid); end
        ack_line(line_a);
        tests_run++; if (bus.cpu_rvalid !== 1'b1) begin tests_failed++; $display("[TB] FAIL cold_rvalid: got %b want 1", bus.cpu_rvalid); end
        tests_run++; if (bus.cpu_rdata !== 8'hA5) begin tests_failed++; $display("[TB] FAIL cold_rdata: got %h want a5", bus.cpu_rdata); end
        tests_run++; if (bus.arr_we !== 1'b1) begin tests_failed++; $display("[TB] FAIL cold_arr_we: got %b want 1", bus.arr_we); end
        tests_run++; if (bus.arr_widx !== 4'd9) begin tests_failed++; $display("[TB] FAIL cold_arr_widx: got %0d want 9", bus.arr_widx); end
        tests_run++; if (bus.arr_wdata !== line_a) begin tests_failed++; $display("[TB] FAIL cold_arr_wdata: got %h want %h", bus.arr_wdata, line_a); end
        tests_run++; if (bus.mem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL cold_req_drop: got %b want 0", bus.mem_req); end
        cycle();
        tests_run++; if (bus.cpu_rvalid !== 1'b0 || bus.arr_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL cold_pulse: got rvalid=%b we=%b want 0/0", bus.cpu_rvalid, bus.arr_we); end
        tests_run++; if (bus.cpu_rdata !== 8'hA5) begin tests_failed++; $display("[TB] FAIL cold_rdata_hold: got %h want a5", bus.cpu_rdata); end
    endtask

    task automatic test_hit();
        start_req(32'h0000_0123);
        tests_run++; if (bus.cpu_rvalid !== 1'b0) begin tests_failed++; $display("[TB] FAIL hit_rvalid_early: got %b want 0", bus.cpu_rvalid); end
        cycle();
        tests_run++; if (bus.cpu_rvalid !== 1'b1) begin tests_failed++; $display("[TB] FAIL hit_rvalid: got %b want 1", bus.cpu_rvalid); end
        tests_run++; if (bus.cpu_rdata !== 8'hA5) begin tests_failed++; $display("[TB] FAIL hit_rdata: got %h want a5", bus.cpu_rdata); end
        tests_run++; if (bus.mem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL hit_no_mem_req: got %b want 0", bus.mem_req); end
        start_req(32'h0000_0125);
        cycle();
        tests_run++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 8'hAB) begin tests_failed++; $display("[TB] FAIL hit_off5: got rvalid=%b rdata=%h want 1/ab", bus.cpu_rvalid, bus.cpu_rdata); end
        cycle();
    endtask

    task automatic test_conflict();
        start_req(32'h0000_0323);
        cycle();
        tests_run++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0000_0320) begin tests_failed++; $display("[TB] FAIL conflict_miss: got req=%b addr=%h want 1/00000320", bus.mem_req, bus.mem_addr); end
        ack_line(line_b);
        tests_run++; if (bus.cpu_rdata !== 8'h19 || bus.arr_widx !== 4'd9) begin tests_failed++; $display("[TB] FAIL conflict_fill: got rdata=%h widx=%0d want 19/9", bus.cpu_rdata, bus.arr_widx); end
        cycle();
        start_req(32'h0000_0123);
        cycle();
        tests_run++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0000_0120) begin tests_failed++; $display("[TB] FAIL conflict_evict: got req=%b addr=%h want 1/00000120", bus.mem_req, bus.mem_addr); end
        ack_line(line_a);
        tests_run++; if (bus.cpu_rdata !== 8'hA5) begin tests_failed++; $display("[TB] FAIL conflict_refill: got %h want a5", bus.cpu_rdata); end
        cycle();
    endtask

    task automatic test_back_to_back();
        start_req(32'h0000_0100);
        cycle();
        tests_run++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0000_0100) begin tests_failed++; $display("[TB] FAIL b2b_miss: got req=%b addr=%h want 1/00000100", bus.mem_req, bus.mem_addr); end
        ack_line(line_c);
        tests_run++; if (bus.cpu_rdata !== 8'h40 || bus.cpu_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_fill: got rdata=%h ready=%b want 40/1", bus.cpu_rdata, bus.cpu_ready); end
        start_req(32'h0000_011F);
        tests_run++; if (bus.cpu_rvalid !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_rvalid_early: got %b want 0", bus.cpu_rvalid); end
        cycle();
        tests_run++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 8'h9D || bus.mem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_hit: got rvalid=%b rdata=%h req=%b want 1/9d/0", bus.cpu_rvalid, bus.cpu_rdata, bus.mem_req); end
        cycle();
    endtask

    task automatic test_spurious_ack();
        ack_line(make_line(8'hEE));
        tests_run++; if (bus.arr_we !== 1'b0 || bus.cpu_rvalid !== 1'b0 || bus.mem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL spurious_ack: got we=%b rvalid=%b req=%b want 0/0/0", bus.arr_we, bus.cpu_rvalid, bus.mem_req); end
        start_req(32'h0000_0123);
        cycle();
        tests_run++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 8'hA5) begin tests_failed++; $display("[TB] FAIL spurious_hit: got rvalid=%b rdata=%h want 1/a5", bus.cpu_rvalid, bus.cpu_rdata); end
        cycle();
    endtask

    task automatic test_flush_idle();
        bus.flush = 1'b1; bus.cpu_req = 1'b1; bus.cpu_addr = 32'h0000_0123;
        #1;
        tests_run++; if (bus.cpu_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_ready: got %b want 0", bus.cpu_ready); end
        cycle();
        bus.flush = 1'b0;
        #1;
        tests_run++; if (bus.cpu_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL flush_not_accepted: got ready=%b want 1", bus.cpu_ready); end
        cycle();
        bus.cpu_req = 1'b0;
        cycle();
        tests_run++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0000_0120) begin tests_failed++; $display("[TB] FAIL flush_idle_miss: got req=%b addr=%h want 1/00000120", bus.mem_req, bus.mem_addr); end
        ack_line(line_a);
        tests_run++; if (bus.cpu_rdata !== 8'hA5) begin tests_failed++; $display("[TB] FAIL flush_idle_fill: got %h want a5", bus.cpu_rdata); end
        cycle();
    endtask

    task automatic test_flush_miss();
        start_req(32'h0000_0323);
        cycle();
        tests_run++; if (bus.mem_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL fmiss_req: got %b want 1", bus.mem_req); end
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        cycle();
        ack_line(line_b);
        tests_run++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 8'h19) begin tests_failed++; $display("[TB] FAIL fmiss_fill: got rvalid=%b rdata=%h want 1/19", bus.cpu_rvalid, bus.cpu_rdata); end
        tests_run++; if (bus.cpu_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL fmiss_pend_ready: got %b want 0", bus.cpu_ready); end
        cycle();
        tests_run++; if (bus.cpu_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL fmiss_ready_after: got %b want 1", bus.cpu_ready); end
        start_req(32'h0000_0323);
        cycle();
        tests_run++; if (bus.mem_req !== 1'b1 || bus.cpu_rvalid !== 1'b0) begin tests_failed++; $display("[TB] FAIL fmiss_cleared: got req=%b rvalid=%b want 1/0", bus.mem_req, bus.cpu_rvalid); end
        ack_line(line_b);
        cycle();
    endtask

    task automatic test_reset_mid_miss();
        start_req(32'h0000_0123);
        cycle();
        tests_run++; if (bus.mem_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL rmid_req: got %b want 1", bus.mem_req); end
        rst_n = 1'b0;
        #1;
        tests_run++; if (bus.mem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL rmid_async_drop: got %b want 0", bus.mem_req); end
        @(negedge clk);
        rst_n = 1'b1;
        ack_line(line_a);
        tests_run++; if (bus.cpu_rvalid !== 1'b0 || bus.arr_we !== 1'b0 || bus.mem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL rmid_late_ack: got rvalid=%b we=%b req=%b want 0/0/0", bus.cpu_rvalid, bus.arr_we, bus.mem_req); end
        tests_run++; if (bus.cpu_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rmid_idle: got ready=%b want 1", bus.cpu_ready); end
    endtask

`ifdef CACHE_STATS_EN
    task automatic test_stats();
        tests_run++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin tests_failed++; $display("[TB] FAIL stats_reset: got hit=%0d miss=%0d want 0/0", hit_cnt, miss_cnt); end
        start_req(32'h0000_0123);
        cycle();
        ack_line(line_a);
        cycle();
        for (int i = 0; i < 3; i++) begin
            start_req(32'h0000_0123);
            cycle();
        end
        tests_run++; if (hit_cnt !== 32'd3 || miss_cnt !== 32'd1) begin tests_failed++; $display("[TB] FAIL stats_count: got hit=%0d miss=%0d want 3/1", hit_cnt, miss_cnt); end
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        cycle();
        tests_run++; if (hit_cnt !== 32'd3 || miss_cnt !== 32'd1) begin tests_failed++; $display("[TB] FAIL stats_flush: got hit=%0d miss=%0d want 3/1", hit_cnt, miss_cnt); end
    endtask
`endif

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) arr_mem[i] = '0;
        line_a = make_line(8'h9C);
        line_b = make_line(8'h10);
        line_c = make_line(8'h40);
        @(negedge clk);
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_back_to_back();
        test_spurious_ack();
        test_flush_idle();
        test_flush_miss();
        test_reset_mid_miss();
`ifdef CACHE_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
